// File: rtl/ball_motion_engine.sv
// Ball mover: per tick advances the ball up to MAX_STEP px per axis (X first, then Y),
// scanning the leading edge through an external latency-READ_LATENCY map port before
// each 1-px step and resolving holes, win tile and walls.
module ball_motion_engine #(
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned RADIUS       = 7,
  parameter int unsigned MAX_STEP     = 4,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned INIT_X       = 527,
  parameter int unsigned INIT_Y       = 254,
  parameter int unsigned WIN_X        = 313,
  parameter int unsigned WIN_Y        = 48,
  parameter logic [7:0]  WALL         = 8'h26,
  parameter logic [7:0]  HOLE         = 8'h49,
  parameter logic [7:0]  WIN          = 8'hF9,
  parameter int unsigned LIVES        = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [3:0]         dir,
  input  logic [2:0]         step,
  output logic [COORD_W-1:0] map_col,
  output logic [COORD_W-1:0] map_row,
  input  logic [7:0]         map_pix,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               busy,
  output logic               hole_pulse,
  output logic [3:0]         lives_left,
  output logic               won,
  output logic               gameover
);

  localparam int unsigned ScanN = 2 * RADIUS + 1;
  localparam int unsigned ScanW = (ScanN > 1) ? $clog2(ScanN) : 1;
  localparam int unsigned WaitW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned StepW = $clog2(MAX_STEP + 1);
  localparam int unsigned CW    = COORD_W + 1;

  typedef enum logic [2:0] {
    StIdle, StLoad, StIssue, StWait, StEval, StCommit, StOver
  } state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, y_q, col_q, row_q;
  logic [3:0]         dir_q;
  logic [2:0]         step_q;
  logic               axis_y_q;  // 0: scanning/moving X, 1: Y
  logic [StepW-1:0]   rem_q;
  logic [ScanW-1:0]   scan_q;
  logic [WaitW-1:0]   wait_q;
  logic               hole_seen_q, win_seen_q, wall_seen_q;
  logic               hole_pulse_q, won_q, over_q;
  logic [3:0]         lives_q;

  logic               tick_go, x_act, x_neg, y_act, y_neg, mv_neg, more_y;
  logic               edge_oob, scan_last, wait_last;
  logic [StepW-1:0]   n_eff;
  logic [COORD_W-1:0] centre_mv, centre_cr, cross_c, issue_col, issue_row;
  logic [CW-1:0]      edge_c;

  // Effective direction, clamped step and leading-edge scan address
  always_comb begin
    tick_go   = tick && (step != 3'd0) && ((dir[3] ^ dir[2]) || (dir[1] ^ dir[0]));
    x_act     = dir_q[3] ^ dir_q[2];
    x_neg     = dir_q[2];
    y_act     = dir_q[1] ^ dir_q[0];
    y_neg     = dir_q[0];
    n_eff     = (32'(step_q) > MAX_STEP) ? StepW'(MAX_STEP) : StepW'(step_q);
    more_y    = !axis_y_q && y_act;
    mv_neg    = axis_y_q ? y_neg : x_neg;
    centre_mv = axis_y_q ? y_q : x_q;
    centre_cr = axis_y_q ? x_q : y_q;
    // Extra MSB catches both underflow and overflow of the edge coordinate
    edge_c    = mv_neg ? ({1'b0, centre_mv} - CW'(RADIUS + 1))
                       : ({1'b0, centre_mv} + CW'(RADIUS + 1));
    edge_oob  = edge_c[COORD_W];
    cross_c   = centre_cr - COORD_W'(RADIUS) + COORD_W'(scan_q);
    issue_col = axis_y_q ? cross_c : edge_c[COORD_W-1:0];
    issue_row = axis_y_q ? edge_c[COORD_W-1:0] : cross_c;
    scan_last = (scan_q == ScanW'(ScanN - 1));
    wait_last = (wait_q == WaitW'(READ_LATENCY - 1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (tick_go) state_d = StLoad;
      StLoad:   state_d = StIssue;
      StIssue:  state_d = edge_oob ? StEval : StWait;
      StWait:   if (wait_last) state_d = scan_last ? StEval : StIssue;
      StEval: begin
        if (hole_seen_q)      state_d = (lives_q == 4'd1) ? StOver : StIdle;
        else if (win_seen_q)  state_d = StOver;
        else if (wall_seen_q) state_d = more_y ? StIssue : StIdle;
        else                  state_d = StCommit;
      end
      StCommit: begin
        if (rem_q == StepW'(1)) state_d = more_y ? StIssue : StIdle;
        else                    state_d = StIssue;
      end
      StOver:   state_d = StOver;
      default:  state_d = StIdle;
    endcase
  end

  // State register and move datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      x_q          <= COORD_W'(INIT_X);
      y_q          <= COORD_W'(INIT_Y);
      col_q        <= '0;
      row_q        <= '0;
      dir_q        <= '0;
      step_q       <= '0;
      axis_y_q     <= 1'b0;
      rem_q        <= '0;
      scan_q       <= '0;
      wait_q       <= '0;
      hole_seen_q  <= 1'b0;
      win_seen_q   <= 1'b0;
      wall_seen_q  <= 1'b0;
      hole_pulse_q <= 1'b0;
      won_q        <= 1'b0;
      over_q       <= 1'b0;
      lives_q      <= 4'(LIVES);
    end else begin
      state_q      <= state_d;
      hole_pulse_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (tick_go) begin
            dir_q  <= dir;
            step_q <= step;
          end
        end
        StLoad: begin
          axis_y_q    <= !x_act;
          rem_q       <= n_eff;
          scan_q      <= '0;
          hole_seen_q <= 1'b0;
          win_seen_q  <= 1'b0;
          wall_seen_q <= 1'b0;
        end
        StIssue: begin
          if (edge_oob) begin
            wall_seen_q <= 1'b1;
          end else begin
            col_q  <= issue_col;
            row_q  <= issue_row;
            wait_q <= '0;
          end
        end
        StWait: begin
          wait_q <= wait_q + WaitW'(1);
          if (wait_last) begin
            if (map_pix == HOLE) hole_seen_q <= 1'b1;
            if (map_pix == WIN)  win_seen_q  <= 1'b1;
            if (map_pix == WALL) wall_seen_q <= 1'b1;
            scan_q <= scan_q + ScanW'(1);
          end
        end
        StEval: begin
          if (hole_seen_q) begin
            hole_pulse_q <= 1'b1;
            lives_q      <= lives_q - 4'd1;
            x_q          <= COORD_W'(INIT_X);
            y_q          <= COORD_W'(INIT_Y);
            if (lives_q == 4'd1) over_q <= 1'b1;
          end else if (win_seen_q) begin
            x_q    <= COORD_W'(WIN_X);
            y_q    <= COORD_W'(WIN_Y);
            won_q  <= 1'b1;
            over_q <= 1'b1;
          end else if (wall_seen_q && more_y) begin
            axis_y_q    <= 1'b1;
            rem_q       <= n_eff;
            scan_q      <= '0;
            wall_seen_q <= 1'b0;
          end
        end
        StCommit: begin
          if (axis_y_q) y_q <= y_neg ? (y_q - COORD_W'(1)) : (y_q + COORD_W'(1));
          else          x_q <= x_neg ? (x_q - COORD_W'(1)) : (x_q + COORD_W'(1));
          rem_q       <= rem_q - StepW'(1);
          scan_q      <= '0;
          hole_seen_q <= 1'b0;
          win_seen_q  <= 1'b0;
          wall_seen_q <= 1'b0;
          if ((rem_q == StepW'(1)) && more_y) begin
            axis_y_q <= 1'b1;
            rem_q    <= n_eff;
          end
        end
        default: ;
      endcase
    end
  end

  // Output mapping
  always_comb begin
    map_col    = col_q;
    map_row    = row_q;
    x_out      = x_q;
    y_out      = y_q;
    busy       = (state_q != StIdle) && (state_q != StOver);
    hole_pulse = hole_pulse_q;
    lives_left = lives_q;
    won        = won_q;
    gameover   = over_q;
  end

endmodule

// File: tb/tb_ball_motion_engine.sv
// Bench for ball_motion_engine: directed scenarios plus random moves over a random map,
// checked against a pixel-level behavioural model of the labyrinth rules.
module tb_ball_motion_engine;

  localparam int R  = 7;
  localparam int MS = 4;
  localparam int RL = 3;
  localparam int IX = 527;
  localparam int IY = 254;
  localparam int WX = 313;
  localparam int WY = 48;
  localparam int LV = 3;
  localparam logic [7:0] P_WALL = 8'h26;
  localparam logic [7:0] P_HOLE = 8'h49;
  localparam logic [7:0] P_WIN  = 8'hF9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] dir = 4'd0;
  logic [2:0] step = 3'd0;
  logic [9:0] map_col, map_row, x_out, y_out;
  logic [7:0] map_pix;
  logic       busy, hole_pulse, won, gameover;
  logic [3:0] lives_left;

  always #5 clk = ~clk;

  ball_motion_engine dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .dir        (dir),
    .step       (step),
    .map_col    (map_col),
    .map_row    (map_row),
    .map_pix    (map_pix),
    .x_out      (x_out),
    .y_out      (y_out),
    .busy       (busy),
    .hole_pulse (hole_pulse),
    .lives_left (lives_left),
    .won        (won),
    .gameover   (gameover)
  );

  // Sparse map, key = row*1024+col, absent = free
  logic [7:0] map_mem [int];

  function automatic logic [7:0] map_lookup(input logic [9:0] c, input logic [9:0] r);
    int k;
    k = int'(r) * 1024 + int'(c);
    if (map_mem.exists(k)) return map_mem[k];
    return 8'h00;
  endfunction

  // Read port: data for an address registered at edge E is sampled at edge E+RL
  logic [7:0] pix_d1, pix_d2;
  always @(posedge clk) begin
    pix_d1 <= map_lookup(map_col, map_row);
    pix_d2 <= pix_d1;
  end
  assign map_pix = pix_d2;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_x, m_y, m_lives;
  bit m_won, m_over;
  int exp_addr [$];
  int exp_holes, exp_busy;

  task automatic model_reset();
    m_x = IX; m_y = IY; m_lives = LV; m_won = 0; m_over = 0;
  endtask

  task automatic model_tick(input logic [3:0] d, input int s);
    int sg [2];
    int n;
    bit stop;
    exp_addr.delete();
    exp_holes = 0;
    exp_busy = 0;
    sg[0] = int'(d[3]) - int'(d[2]);
    sg[1] = int'(d[1]) - int'(d[0]);
    if (m_over || s == 0 || (sg[0] == 0 && sg[1] == 0)) return;
    n = (s > MS) ? MS : s;
    exp_busy = 1;
    stop = 0;
    for (int ax = 0; ax < 2; ax++) begin
      if (stop || sg[ax] == 0) continue;
      for (int k = 0; k < n; k++) begin
        int edge_c, cross0, cr, col, row;
        bit f_hole, f_win, f_wall;
        logic [7:0] p;
        logic [31:0] cv, rv;
        f_hole = 0; f_win = 0; f_wall = 0;
        edge_c = (ax == 0 ? m_x : m_y) + sg[ax] * (R + 1);
        cross0 = (ax == 0 ? m_y : m_x) - R;
        if (edge_c < 0 || edge_c > 1023) begin
          f_wall = 1;
          exp_busy += 2;
        end else begin
          for (int i = 0; i < 2 * R + 1; i++) begin
            cr = (cross0 + i) & 1023;
            col = (ax == 0) ? edge_c : cr;
            row = (ax == 0) ? cr : edge_c;
            exp_addr.push_back(col * 1024 + row);
            cv = col; rv = row;
            p = map_lookup(cv[9:0], rv[9:0]);
            if (p == P_HOLE) f_hole = 1;
            if (p == P_WIN)  f_win = 1;
            if (p == P_WALL) f_wall = 1;
          end
          exp_busy += (2 * R + 1) * (RL + 1) + 1;
        end
        if (f_hole) begin
          exp_holes++;
          m_lives--;
          m_x = IX; m_y = IY;
          if (m_lives == 0) m_over = 1;
          stop = 1;
          break;
        end else if (f_win) begin
          m_x = WX; m_y = WY; m_won = 1; m_over = 1;
          stop = 1;
          break;
        end else if (f_wall) begin
          break;
        end else begin
          if (ax == 0) m_x += sg[0];
          else         m_y += sg[1];
          exp_busy++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One tick through DUT and model; extra_at>0 pulses a second tick that many cycles in
  task automatic run_tick(input logic [3:0] d, input int s, input int extra_at);
    int reads, holes, busy_cnt, prev, cur;
    bit done;
    logic [31:0] sv;
    model_tick(d, s);
    reads = 0; holes = 0; busy_cnt = 0; done = 0;
    sv = s;
    @(negedge clk);
    prev = int'(map_col) * 1024 + int'(map_row);
    dir = d; step = sv[2:0]; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      cur = int'(map_col) * 1024 + int'(map_row);
      if (cur != prev) begin
        if (reads < exp_addr.size()) check_eq("read_addr", cur, exp_addr[reads]);
        reads++;
        prev = cur;
      end
      if (hole_pulse) holes++;
      if (!busy) begin
        done = 1;
        break;
      end
      busy_cnt++;
      if (extra_at != 0 && c == extra_at) begin
        tick = 1'b1; dir = 4'b0100; step = 3'd4;
      end else begin
        tick = 1'b0;
      end
      @(negedge clk);
    end
    tick = 1'b0;
    check_eq("busy_drops", int'(done), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cur = int'(map_col) * 1024 + int'(map_row);
      if (cur != prev) begin
        reads++;
        prev = cur;
      end
      if (hole_pulse) holes++;
    end
    check_eq("busy_cycles", busy_cnt, exp_busy);
    check_eq("reads", reads, exp_addr.size());
    check_eq("hole_pulses", holes, exp_holes);
    check_eq("x_out", int'(x_out), m_x);
    check_eq("y_out", int'(y_out), m_y);
    check_eq("lives", int'(lives_left), m_lives);
    check_eq("won", int'(won), int'(m_won));
    check_eq("gameover", int'(gameover), int'(m_over));
    check_eq("busy_idle", int'(busy), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_x"}, int'(x_out), IX);
    check_eq({tag, "_y"}, int'(y_out), IY);
    check_eq({tag, "_lives"}, int'(lives_left), LV);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_won"}, int'(won), 0);
    check_eq({tag, "_gameover"}, int'(gameover), 0);
    check_eq({tag, "_hole"}, int'(hole_pulse), 0);
    check_eq({tag, "_col"}, int'(map_col), 0);
    check_eq({tag, "_row"}, int'(map_row), 0);
  endtask

  initial begin
    logic [3:0] rd;
    int rs, rv, rc, rr;
    model_reset();
    do_reset();
    check_reset_vals("rst");

    // Free move right by 3
    run_tick(4'b1000, 3, 0);
    check_eq("t1_x", int'(x_out), 530);
    check_eq("t1_y", int'(y_out), 254);

    // Wall at column 537, all rows
    do_reset();
    for (int r = 0; r < 1024; r++) map_mem[r * 1024 + 537] = P_WALL;
    run_tick(4'b1000, 4, 0);
    check_eq("t2_x", int'(x_out), 529);
    run_tick(4'b1010, 2, 0);
    check_eq("t3_x", int'(x_out), 529);
    check_eq("t3_y", int'(y_out), 256);

    // Opposing directions, zero step, step clamp
    map_mem.delete();
    do_reset();
    run_tick(4'b1100, 4, 0);
    run_tick(4'b0011, 4, 0);
    run_tick(4'b1000, 0, 0);
    run_tick(4'b1000, 7, 0);
    check_eq("clamp_x", int'(x_out), 531);

    // Hole one px right of the edge, three times
    do_reset();
    map_mem[254 * 1024 + 535] = P_HOLE;
    run_tick(4'b1000, 1, 0);
    check_eq("t4_lives", int'(lives_left), 2);
    run_tick(4'b1000, 1, 0);
    run_tick(4'b1000, 1, 0);
    check_eq("t4_over", int'(gameover), 1);
    check_eq("t4_won", int'(won), 0);

    // Win tile on the upper edge; later ticks inert
    map_mem.delete();
    do_reset();
    map_mem[246 * 1024 + 527] = P_WIN;
    run_tick(4'b0001, 1, 0);
    check_eq("t5_x", int'(x_out), WX);
    check_eq("t5_won", int'(won), 1);
    run_tick(4'b1000, 2, 0);

    // Tick while busy is ignored; reset mid-scan restores everything
    map_mem.delete();
    do_reset();
    run_tick(4'b1000, 1, 20);
    check_eq("t6_x", int'(x_out), 528);
    @(negedge clk);
    dir = 4'b1000; step = 3'd4; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("t6_busy_mid", int'(busy), 1);
    reset = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_reset_vals("t6_rst");
    reset = 1'b0;
    model_reset();

    // Random moves over a random map near the spawn
    do_reset();
    for (int f = 0; f < 50; f++) begin
      rc = 505 + $urandom_range(0, 44);
      rr = 232 + $urandom_range(0, 44);
      rv = $urandom_range(0, 11);
      map_mem[rr * 1024 + rc] = (rv < 6) ? P_WALL : (rv < 8) ? P_HOLE :
                                (rv < 9) ? P_WIN : 8'h11;
    end
    for (int t = 0; t < 45; t++) begin
      rd = 4'($urandom);
      rs = $urandom_range(0, 7);
      run_tick(rd, rs, 0);
      if (m_over) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
